// File: rtl/dff_chain_pkg.sv
// Shared constants, types and helpers for the DFF-chain deserializer.
// Build option DFF_DESER_PARITY_EN appends one even-parity bit to every frame.
package dff_chain_pkg;

   localparam int unsigned DESER_WIDTH_DEF = 8;

`ifdef DFF_DESER_PARITY_EN
   localparam int unsigned DESER_PAR_BITS = 1;
`else
   localparam int unsigned DESER_PAR_BITS = 0;
`endif

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      if (value > 1) begin
         for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dff_deser_shift.sv
// Serial-to-parallel shift register with frame bit counter; o_done pulses
// combinationally on the frame's final bit with the completed word on o_word.
module dff_deser_shift
   import dff_chain_pkg::*;
#(
   parameter int unsigned  WIDTH     = DESER_WIDTH_DEF,
   parameter int unsigned  MSB_FIRST = 1,
   localparam int unsigned FRAME_LEN = WIDTH + DESER_PAR_BITS,
   localparam int unsigned CNT_W     = clog2(FRAME_LEN + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_bit,
   input  logic             i_valid,
   output logic [WIDTH-1:0] o_word,
   output logic             o_done,
`ifdef DFF_DESER_PARITY_EN
   output logic             o_par_err,
`endif
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_sr_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;
   logic             w_data_bit;

   assign w_last = i_valid && (r_cnt == CNT_W'(FRAME_LEN - 1));

   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign w_shifted = {r_sr[WIDTH-2:0], i_bit};
      end else begin : g_lsb
         assign w_shifted = {i_bit, r_sr[WIDTH-1:1]};
      end
   endgenerate

`ifdef DFF_DESER_PARITY_EN
   // The parity bit is folded into r_par only; it never enters the data word.
   logic r_par;

   assign w_data_bit = (r_cnt != CNT_W'(WIDTH));
   assign o_par_err  = r_par ^ i_bit;

   always_ff @(posedge i_clk) begin
      if (i_rst || w_last) begin
         r_par <= 1'b0;
      end else if (i_valid) begin
         r_par <= r_par ^ i_bit;
      end
   end
`else
   assign w_data_bit = 1'b1;
`endif

   assign w_sr_next = (i_valid && w_data_bit) ? w_shifted : r_sr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else begin
         r_sr <= w_sr_next;
         if (i_valid) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end

   assign o_word  = w_sr_next;
   assign o_done  = w_last;
   assign o_count = r_cnt;

endmodule

// File: rtl/dff_chain_deserializer.sv
// Deserializes the delay chain's serial stream into WIDTH-bit words on a
// valid/ready port with sticky overflow. Option: DFF_DESER_PARITY_EN.
module dff_chain_deserializer
   import dff_chain_pkg::*;
#(
   parameter int unsigned  WIDTH     = DESER_WIDTH_DEF,
   parameter int unsigned  MSB_FIRST = 1,
   localparam int unsigned CNT_W     = clog2(WIDTH + DESER_PAR_BITS + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overflow,
`ifdef DFF_DESER_PARITY_EN
   output logic             parity_err,
`endif
   output logic [CNT_W-1:0] bit_count
);

   slot_state_t      r_state;
   slot_state_t      w_state_next;
   logic [WIDTH-1:0] w_word;
   logic             w_done;
   logic             w_free;
   logic             w_load;
   logic             w_drop;
`ifdef DFF_DESER_PARITY_EN
   logic             w_par_err;
`endif

   dff_deser_shift #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_bit     (bit_in),
      .i_valid   (bit_valid),
      .o_word    (w_word),
      .o_done    (w_done),
`ifdef DFF_DESER_PARITY_EN
      .o_par_err (w_par_err),
`endif
      .o_count   (bit_count)
   );

   // A held slot that is consumed on this edge can take the new word directly.
   assign w_free = (r_state == SLOT_EMPTY) || word_ready;
   assign w_load = w_done && w_free;
   assign w_drop = w_done && !w_free;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SLOT_EMPTY: if (w_load) w_state_next = SLOT_FULL;
         SLOT_FULL: begin
            if (w_load) begin
               w_state_next = SLOT_FULL;
            end else if (word_ready) begin
               w_state_next = SLOT_EMPTY;
            end
         end
         default: w_state_next = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= SLOT_EMPTY;
         word_out   <= '0;
         overflow   <= 1'b0;
`ifdef DFF_DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if (w_load) begin
            word_out   <= w_word;
`ifdef DFF_DESER_PARITY_EN
            parity_err <= w_par_err;
`endif
         end
         if (w_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign word_valid = (r_state == SLOT_FULL);

endmodule

// File: tb/tb_dff_chain_deserializer.sv
// Directed bench for dff_chain_deserializer: MSB-first and LSB-first instances
// share one stimulus stream. Parity checks run when DFF_DESER_PARITY_EN is set.
module tb_dff_chain_deserializer;
   import dff_chain_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = clog2(W + DESER_PAR_BITS + 1);

   logic          CLK = 1'b0;
   logic          RST;
   logic          bit_in;
   logic          bit_valid;
   logic          word_ready;
   logic [W-1:0]  m_word,  l_word;
   logic          m_valid, l_valid;
   logic          m_ovf,   l_ovf;
   logic [CW-1:0] m_cnt,   l_cnt;
`ifdef DFF_DESER_PARITY_EN
   logic          m_perr,  l_perr;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] d;

   always #5 CLK = ~CLK;

   dff_chain_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .CLK(CLK), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid),
      .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
      .overflow(m_ovf),
`ifdef DFF_DESER_PARITY_EN
      .parity_err(m_perr),
`endif
      .bit_count(m_cnt)
   );

   dff_chain_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .CLK(CLK), .RST(RST), .bit_in(bit_in), .bit_valid(bit_valid),
      .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
      .overflow(l_ovf),
`ifdef DFF_DESER_PARITY_EN
      .parity_err(l_perr),
`endif
      .bit_count(l_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
   endtask

   // Sends one frame MSB-first; rdy_last raises word_ready for the final bit.
   task automatic send_frame(input logic [7:0] fd, input logic rdy_last);
      for (int i = 7; i >= 0; i--) begin
`ifndef DFF_DESER_PARITY_EN
         if (i == 0 && rdy_last) word_ready = 1'b1;
`endif
         send_bit(fd[i]);
      end
`ifdef DFF_DESER_PARITY_EN
      if (rdy_last) word_ready = 1'b1;
      send_bit(^fd);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
      tick(); tick();
      RST = 1'b0;
      chk("init_valid", 32'(m_valid), 0);
      chk("init_cnt",   32'(m_cnt),   0);

      // Fill the slot, force an overflow, then leave a partial word of 5 bits.
      send_frame(8'hFF, 1'b0);
      chk("pre_valid", 32'(m_valid), 1);
      chk("pre_word",  32'(m_word),  32'hFF);
      send_frame(8'hFF, 1'b0);
      chk("pre_ovf",   32'(m_ovf),   1);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("pre_cnt",   32'(m_cnt),   5);

      RST = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; word_ready = 1'b1;
      tick(); tick();
      RST = 1'b0; bit_valid = 1'b0;
      chk("rst_cnt",   32'(m_cnt),   0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_ovf",   32'(m_ovf),   0);
      chk("rst_word",  32'(m_word),  0);
      chk("rst_lcnt",  32'(l_cnt),   0);

      // Basic word, consumer always ready.
      d = 8'hA5;
      send_frame(d, 1'b0);
      chk("basic_word",  32'(m_word),  32'hA5);
      chk("basic_valid", 32'(m_valid), 1);
      chk("basic_cnt",   32'(m_cnt),   0);
      tick();
      chk("basic_consumed", 32'(m_valid), 0);
      chk("basic_hold",     32'(m_word),  32'hA5);

      // LSB-first with idle gaps between bits.
      for (int i = 7; i >= 1; i--) begin
         send_bit(d[i]);
         tick();
         if (i == 5) chk("gap_cnt", 32'(l_cnt), 3);
      end
      send_bit(d[0]);
`ifdef DFF_DESER_PARITY_EN
      tick();
      send_bit(^d);
`endif
      chk("lsb_word",  32'(l_word),  32'hA5);
      chk("lsb_valid", 32'(l_valid), 1);
      tick();

      // Back-to-back: second word loads on the edge that consumes the first.
      send_frame(8'h3C, 1'b0);
      chk("b2b_w1",    32'(m_word),  32'h3C);
      chk("b2b_v1",    32'(m_valid), 1);
      word_ready = 1'b0;
      send_frame(8'hC3, 1'b1);
      chk("b2b_w2",    32'(m_word),  32'hC3);
      chk("b2b_v2",    32'(m_valid), 1);
      chk("b2b_ovf",   32'(m_ovf),   0);
      tick();
      chk("b2b_drain", 32'(m_valid), 0);

      // Overflow: second word dropped while the first is held.
      word_ready = 1'b0;
      send_frame(8'h11, 1'b0);
      chk("ovf_w1",    32'(m_word),  32'h11);
      chk("ovf_lw1",   32'(l_word),  32'h88);
      chk("ovf_none",  32'(m_ovf),   0);
      send_frame(8'h22, 1'b0);
      chk("ovf_hold",  32'(m_word),  32'h11);
      chk("ovf_set",   32'(m_ovf),   1);
      chk("ovf_lset",  32'(l_ovf),   1);
      chk("ovf_valid", 32'(m_valid), 1);
      chk("ovf_cnt",   32'(m_cnt),   0);
      word_ready = 1'b1;
      tick();
      chk("ovf_drain",  32'(m_valid), 0);
      chk("ovf_sticky", 32'(m_ovf),   1);
      send_frame(8'h96, 1'b0);
      chk("ovf_after",  32'(m_word),  32'h96);
      chk("ovf_lafter", 32'(l_word),  32'h69);
      chk("ovf_still",  32'(m_ovf),   1);
      tick();

`ifdef DFF_DESER_PARITY_EN
      d = 8'hA5;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(1'b0);
      chk("par_ok_word", 32'(m_word), 32'hA5);
      chk("par_ok_err",  32'(m_perr), 0);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(1'b1);
      chk("par_bad_err",  32'(m_perr), 1);
      chk("par_bad_lerr", 32'(l_perr), 1);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
